// File: rtl/instr_classify_fifo.sv
// ARM instruction classifier: decodes accepted words into class/condition, buffers them
// in a DEPTH-entry FIFO and keeps saturating per-class occurrence counters.
module instr_classify_fifo #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned COUNT_W   = 16,
  parameter int unsigned NUM_CLASS = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        instruction,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instr,
  output logic [3:0]         out_class,
  output logic [3:0]         out_cond,
  output logic               out_uncond,
  input  logic [3:0]         cnt_sel,
  input  logic               cnt_clear,
  output logic [COUNT_W-1:0] cnt_value
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]        count_q, count_d;
  logic [31:0]        instr_mem_q [DEPTH];
  logic [3:0]         class_mem_q [DEPTH];
  logic [COUNT_W-1:0] cnt_q [NUM_CLASS];
  logic [COUNT_W-1:0] cnt_d [NUM_CLASS];
  logic [COUNT_W-1:0] cnt_sel_val;
  logic [COUNT_W-1:0] cnt_value_q;
  logic               full, push, pop;
  logic [3:0]         in_class;

  // First match wins; encodings matching no rule fall back to UNDEF.
  function automatic logic [3:0] classify(input logic [31:0] b);
    logic [3:0] c;
    if (b[27:22] == 6'b000000 && b[7:4] == 4'b1001) begin
      c = 4'd1;
    end else if (b[27:23] == 5'b00001 && b[7:4] == 4'b1001) begin
      c = 4'd2;
    end else if (b[27:23] == 5'b00010 && b[21:20] == 2'b00 && b[11:4] == 8'b00001001) begin
      c = 4'd3;
    end else if (b[27:25] == 3'b000 && b[7] && b[4] && b[6:5] != 2'b00) begin
      c = 4'd4;
    end else if (b[27:25] == 3'b001) begin
      c = 4'd5;
    end else if (b[27:25] == 3'b000 && !b[4]) begin
      c = 4'd6;
    end else if (b[27:25] == 3'b000 && !b[7] && b[4]) begin
      c = 4'd7;
    end else if (b[27:25] == 3'b011 && b[4]) begin
      c = 4'd0;
    end else if (b[27:26] == 2'b01) begin
      c = 4'd8;
    end else if (b[27:25] == 3'b100) begin
      c = 4'd9;
    end else if (b[27:25] == 3'b101) begin
      c = 4'd10;
    end else if (b[27:24] == 4'b1111) begin
      c = 4'd11;
    end else if (b[27:26] == 2'b11) begin
      c = 4'd12;
    end else begin
      c = 4'd0;
    end
    return c;
  endfunction

  assign in_class = classify(instruction);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = out_valid && out_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!push && pop) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      instr_mem_q[wr_ptr_q] <= instruction;
      class_mem_q[wr_ptr_q] <= in_class;
    end
  end

  assign out_valid  = (count_q != '0);
  assign out_instr  = out_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
  assign out_class  = out_valid ? class_mem_q[rd_ptr_q] : 4'h0;
  assign out_cond   = out_instr[31:28];
  assign out_uncond = out_valid && (out_cond == 4'b1111);

  // Codes 11/12 never equal a counter index, so SWI and COPROC go uncounted.
  always_comb begin
    cnt_sel_val = '0;
    for (int i = 0; i < int'(NUM_CLASS); i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_clear) begin
        cnt_d[i] = '0;
      end else if (push && in_class == 4'(i) && cnt_q[i] != '1) begin
        cnt_d[i] = cnt_q[i] + COUNT_W'(1);
      end
      if (cnt_sel == 4'(i)) cnt_sel_val = cnt_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_CLASS); i++) cnt_q[i] <= '0;
      cnt_value_q <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_CLASS); i++) cnt_q[i] <= cnt_d[i];
      cnt_value_q <= cnt_sel_val;
    end
  end

  assign cnt_value = cnt_value_q;

endmodule

// File: tb/tb_instr_classify_fifo.sv
// Randomized bench for instr_classify_fifo against a queue-based reference model with a
// table-driven classifier; directed scenarios cover fill/stall, wrap, saturation and reset.
module tb_instr_classify_fifo;

  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int NCLS  = 11;
  localparam int MAXC  = (1 << CW) - 1;

  localparam logic [31:0] RMASK [13] = '{
    32'h0FC000F0, 32'h0F8000F0, 32'h0FB00FF0, 32'h0E000090, 32'h0E000000, 32'h0E000010,
    32'h0E000090, 32'h0E000010, 32'h0C000000, 32'h0E000000, 32'h0E000000, 32'h0F000000,
    32'h0C000000};
  localparam logic [31:0] RVAL [13] = '{
    32'h00000090, 32'h00800090, 32'h01000090, 32'h00000090, 32'h02000000, 32'h00000000,
    32'h00000010, 32'h06000010, 32'h04000000, 32'h08000000, 32'h0A000000, 32'h0F000000,
    32'h0C000000};
  localparam int RCODE [13] = '{1, 2, 3, 4, 5, 6, 7, 0, 8, 9, 10, 11, 12};

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready, out_uncond, cnt_clear;
  logic [31:0]   instruction, out_instr;
  logic [3:0]    out_class, out_cond, cnt_sel;
  logic [CW-1:0] cnt_value;

  logic [31:0] q_m [$];
  int          cnt_m [NCLS];
  int          cv_m;
  bit          last_acc;
  int          n_checks = 0;
  int          n_fail   = 0;

  instr_classify_fifo #(.DEPTH(DEPTH), .COUNT_W(CW), .NUM_CLASS(NCLS)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instruction (instruction),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_class   (out_class),
    .out_cond    (out_cond),
    .out_uncond  (out_uncond),
    .cnt_sel     (cnt_sel),
    .cnt_clear   (cnt_clear),
    .cnt_value   (cnt_value)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_class(input logic [31:0] b);
    for (int i = 0; i < 13; i++) begin
      if ((b & RMASK[i]) == RVAL[i] && (RCODE[i] != 4 || b[6:5] != 2'b00)) return 4'(RCODE[i]);
    end
    return 4'd0;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] b;
    b = $urandom;
    case ($urandom_range(0, 7))
      1: b = (b & ~32'h0FC000F0) | 32'h00000090;
      2: b = (b & ~32'h0F8000F0) | 32'h00800090;
      3: b = (b & ~32'h0FB00FF0) | 32'h01000090;
      4: b[27:25] = 3'b000;
      5: begin b[27:25] = 3'b000; b[7] = 1'b1; b[4] = 1'b1; end
      6: b[27:24] = 4'hF;
      default: ;
    endcase
    return b;
  endfunction

  // Reference behaviour of one rising edge, using the inputs currently driven.
  task automatic model_edge();
    bit acc, pop;
    int cls;
    if (rst) begin
      q_m.delete();
      for (int i = 0; i < NCLS; i++) cnt_m[i] = 0;
      cv_m = 0;
      last_acc = 1'b1;
    end else begin
      acc = in_valid && (q_m.size() < DEPTH);
      pop = (q_m.size() > 0) && out_ready;
      cv_m = (cnt_sel < NCLS) ? cnt_m[cnt_sel] : 0;
      cls = int'(ref_class(instruction));
      if (cnt_clear) begin
        for (int i = 0; i < NCLS; i++) cnt_m[i] = 0;
      end else if (acc && cls < NCLS && cnt_m[cls] < MAXC) begin
        cnt_m[cls]++;
      end
      if (pop) void'(q_m.pop_front());
      if (acc) q_m.push_back(instruction);
      last_acc = acc;
    end
  endtask

  task automatic check_all();
    check_eq("out_valid", 32'(out_valid), 32'(q_m.size() > 0));
    check_eq("in_ready", 32'(in_ready), 32'(q_m.size() < DEPTH));
    if (q_m.size() > 0) begin
      check_eq("out_instr", out_instr, q_m[0]);
      check_eq("out_class", 32'(out_class), 32'(ref_class(q_m[0])));
      check_eq("out_cond", 32'(out_cond), 32'(q_m[0][31:28]));
      check_eq("out_uncond", 32'(out_uncond), 32'(q_m[0][31:28] == 4'hF));
    end else begin
      check_eq("empty_instr", out_instr, 32'h0);
      check_eq("empty_class", 32'(out_class), 32'h0);
    end
    check_eq("cnt_value", 32'(cnt_value), 32'(cv_m));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  // Present a word and hold it until accepted, bounded by a cycle budget.
  task automatic push_held(input logic [31:0] w);
    int n;
    in_valid = 1'b1;
    instruction = w;
    n = 0;
    do begin
      step();
      n++;
    end while (!last_acc && n < 20);
    if (!last_acc) check_eq("accept_timeout", 32'(n), 32'(0));
    in_valid = 1'b0;
  endtask

  logic [31:0] seq_w [5] = '{32'hE0010392, 32'hE1020091, 32'hE1D000B0, 32'hEA000000, 32'hE7F000F0};
  int          seq_c [5] = '{1, 3, 4, 10, 0};

  initial begin
    rst = 1'b1; in_valid = 1'b0; instruction = '0; out_ready = 1'b0;
    cnt_sel = '0; cnt_clear = 1'b0;
    step();
    step();
    check_eq("rst_in_ready", 32'(in_ready), 32'h1);
    check_eq("rst_out_valid", 32'(out_valid), 32'h0);
    rst = 1'b0;

    // Single ADD.
    out_ready = 1'b1;
    in_valid = 1'b1; instruction = 32'hE0810002;
    step();
    in_valid = 1'b0;
    check_eq("add_valid", 32'(out_valid), 32'h1);
    check_eq("add_class", 32'(out_class), 32'd6);
    check_eq("add_cond", 32'(out_cond), 32'hE);
    check_eq("add_uncond", 32'(out_uncond), 32'h0);
    step();
    check_eq("add_drained", 32'(out_valid), 32'h0);

    // Class sequence, streaming.
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; instruction = seq_w[k];
      step();
      check_eq("seq_class", 32'(out_class), 32'(seq_c[k]));
    end
    in_valid = 1'b0;
    step();

    // Fill with consumer stalled; the fifth word must wait.
    out_ready = 1'b0;
    for (int k = 0; k < DEPTH; k++) push_held(32'hE2800000 + 32'(k));
    check_eq("full_in_ready", 32'(in_ready), 32'h0);
    in_valid = 1'b1; instruction = 32'hE2800004;
    step();
    step();
    check_eq("stall_no_accept", 32'(last_acc), 32'h0);
    check_eq("stall_head", out_instr, 32'hE2800000);
    out_ready = 1'b1;
    push_held(32'hE2800004);
    for (int k = 0; k < DEPTH + 2; k++) step();
    check_eq("drained", 32'(out_valid), 32'h0);

    // Continuous streaming across several pointer wraps.
    for (int k = 0; k < 3 * DEPTH; k++) begin
      in_valid = 1'b1; instruction = 32'hE0800000 + 32'(k);
      step();
      check_eq("stream_head", out_instr, 32'hE0800000 + 32'(k));
    end
    in_valid = 1'b0;
    step();

    // Counter saturation and clear priority.
    cnt_clear = 1'b1; step(); cnt_clear = 1'b0;
    cnt_sel = 4'd5;
    for (int k = 0; k < 20; k++) begin
      in_valid = 1'b1; instruction = 32'hE2811001;
      step();
    end
    in_valid = 1'b0;
    step();
    step();
    check_eq("cnt_saturate", 32'(cnt_value), 32'd15);
    cnt_clear = 1'b1; in_valid = 1'b1; instruction = 32'hE2811001;
    step();
    cnt_clear = 1'b0; in_valid = 1'b0;
    step();
    check_eq("cnt_cleared", 32'(cnt_value), 32'd0);
    cnt_sel = 4'd12;
    step();
    step();
    check_eq("cnt_sel_oob", 32'(cnt_value), 32'd0);

    // Reset with three entries queued and a word on offer.
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) push_held(seq_w[k]);
    in_valid = 1'b1; instruction = seq_w[3];
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    check_eq("mid_rst_valid", 32'(out_valid), 32'h0);
    check_eq("mid_rst_ready", 32'(in_ready), 32'h1);
    for (int i = 0; i < NCLS; i++) begin
      cnt_sel = 4'(i);
      step();
      check_eq("mid_rst_cnt", 32'(cnt_value), 32'd0);
    end

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if (!in_valid || last_acc) begin
        in_valid = ($urandom_range(0, 9) < 7);
        instruction = rand_instr();
      end
      out_ready = ($urandom_range(0, 9) < 6);
      cnt_sel = 4'($urandom_range(0, 15));
      cnt_clear = ($urandom_range(0, 99) < 2);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_classify_fifo.md
Name: instr_classify_fifo

Overview:
- Parametrised successor to the single-cycle instruction-type decoder.
- Accepts 32-bit ARM instruction words over a valid/ready handshake and decodes each into a 4-bit class code plus its condition field.
- Buffers results in a FIFO so a stalled downstream consumer back-pressures the fetch side.
- Keeps per-class saturating occurrence counters, readable through a select port, for profiling.

Parameters:
- DEPTH, 4: FIFO entries; power of two, at least 2.
- COUNT_W, 16: width of each per-class counter.
- NUM_CLASS, 11: number of class counters; fixed by the class map below, do not override.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous to clk, active-high
- in_valid  in  1  instruction present
- in_ready  out  1  block can accept
- instruction  in  32  ARM instruction word
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer takes head
- out_instr  out  32  original word at head
- out_class  out  4  class code at head
- out_cond  out  4  instruction[31:28] at head
- out_uncond  out  1  head cond == 4'b1111
- cnt_sel  in  4  counter select
- cnt_clear  in  1  zero all counters
- cnt_value  out  COUNT_W  selected counter, registered

Behaviour:
- Reset: all of the following are cleared on a rising clk edge with rst=1, and rst overrides every other input, including mid-transfer:
  - FIFO emptied, pointers 0, out_valid=0.
  - out_instr, out_class, out_cond, out_uncond = 0.
  - All counters = 0; cnt_value = 0.
  - in_ready = 1 in the cycle after reset.
- Handshake:
  - Accept when in_valid && in_ready at a rising edge.
  - Pop when out_valid && out_ready.
  - in_ready = !full; it does not depend on out_ready, so a full FIFO stalls the input even in a cycle where it pops.
  - in_valid/instruction must be held until accepted.
- Latency: an accepted word is visible at the head (out_valid=1) in the cycle after acceptance if the FIFO was empty. Output order is acceptance order.
- Simultaneous push/pop on a non-empty, non-full FIFO: occupancy unchanged; both pointers advance and wrap modulo DEPTH.
- Classification, combinational on the input word, stored with the entry. b = instruction; evaluate in this order, first match wins:
  - 1 MUL: b[27:22]=000000, b[7:4]=1001.
  - 2 MUL_LONG: b[27:23]=00001, b[7:4]=1001.
  - 3 SWAP: b[27:23]=00010, b[21:20]=00, b[11:4]=00001001.
  - 4 HALF_XFER: b[27:25]=000, b[7]=1, b[4]=1, b[6:5]!=00.
  - 5 DP_IMM: b[27:25]=001.
  - 6 DP_REG_SHIMM: b[27:25]=000, b[4]=0.
  - 7 DP_REG_SHREG: b[27:25]=000, b[7]=0, b[4]=1.
  - 0 UNDEF: b[27:25]=011, b[4]=1.
  - 8 LDST: b[27:26]=01.
  - 9 BLOCK_XFER: b[27:25]=100.
  - 10 BRANCH: b[27:25]=101.
  - 11 SWI: b[27:24]=1111.
  - 12 COPROC: b[27:26]=11.
  - Codes 13-15 are never produced.
- Counters: index = class code; counters exist for codes 0-10. SWI and COPROC acceptances are not counted.
  - On acceptance, the counter for the accepted class increments by 1.
  - Counters saturate at 2^COUNT_W-1; no wrap.
  - cnt_clear zeroes all counters and has priority over a same-cycle increment; that instruction is not counted.
- Counter read: cnt_value <= counter[cnt_sel] each clock, one-cycle latency. cnt_sel >= 11 reads 0. The value reflects counts before any same-edge increment.

Test Plan:
- Reset then single push 0xE0810002 (ADD r0,r1,r2) with out_ready=1 -> out_valid one cycle later; out_class=6, out_cond=0xE, out_uncond=0; FIFO empty after the pop.
- Push 0xE0010392 (MUL), 0xE1020091 (SWP), 0xE1D000B0 (LDRH), 0xEA000000 (B), 0xE7F000F0 (undef) -> classes 1, 3, 4, 10, 0 in order.
- Hold out_ready=0 and push DEPTH words -> in_ready=0 after the 4th accept; a 5th word is held, not lost. Raise out_ready -> words drain in order and the 5th is accepted once not full.
- Continuous push and pop for 3*DEPTH words with out_ready=1 -> no drops or duplicates; pointers wrap; occupancy stays constant.
- COUNT_W=4: accept 20 DP_IMM words -> cnt_sel=5 reads 15. Assert cnt_clear with a concurrent accept -> reads 0 next.
- Assert rst with the FIFO holding 3 entries and in_valid=1 -> next cycle out_valid=0, in_ready=1, all counters 0, no acceptance that cycle.
